// File: rtl/discrete_mapper_if.sv
// Mapper bus between the cartridge edge (CPU/PPU side) and a discrete-logic mapper core.
interface map_bus #(
  parameter int unsigned ADDR_BITS = 22
);
  logic [15:0]          cpu_addr;
  logic                 cpu_rw;
  logic [7:0]           cpu_data_in;
  logic                 m2;
  logic [7:0]           prg_rdata;
  logic [13:0]          ppu_addr;
  logic                 ppu_rd;
  logic                 ppu_wr;
  logic                 chr_ram;
  logic                 mirroring;
  logic [ADDR_BITS-1:0] prg_addr;
  logic                 prg_oe;
  logic                 prg_we;
  logic [ADDR_BITS-1:0] chr_addr;
  logic                 chr_ce;
  logic                 chr_oe;
  logic                 chr_we;
  logic                 ciram_a10;
  logic                 ciram_ce;
  logic                 wram_ce;
  logic                 cpu_data_oe;
  logic [15:0]          audio;
  logic                 irq;
  logic [7:0]           sst_data_out;

  modport mapper (
    input  cpu_addr, cpu_rw, cpu_data_in, m2, prg_rdata,
    input  ppu_addr, ppu_rd, ppu_wr, chr_ram, mirroring,
    output prg_addr, prg_oe, prg_we, chr_addr, chr_ce, chr_oe, chr_we,
    output ciram_a10, ciram_ce, wram_ce, cpu_data_oe, audio, irq, sst_data_out
  );
endinterface

// File: rtl/discrete_mapper.sv
// Discrete-logic NES mapper (UxROM/CNROM/AxROM/GxROM) with a single latched bank register.
// Optional BUS_CONFLICT_EN: captured write data is ANDed with the ROM byte being read.
module discrete_mapper #(
  parameter int unsigned MODE          = 0,
  parameter int unsigned PRG_BANK_BITS = 4,
  parameter int unsigned CHR_BANK_BITS = 2
) (
  input logic    clk,
  input logic    rst_n,
  map_bus.mapper bus
);
  localparam int unsigned AW       = bus.ADDR_BITS;
  localparam logic [31:0] PRG_MASK = (32'd1 << PRG_BANK_BITS) - 32'd1;
  localparam logic [31:0] CHR_MASK = (32'd1 << CHR_BANK_BITS) - 32'd1;

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;

  state_t      state_q, state_d;
  logic        m2_s1, m2_s2, m2_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  bank_q, bank_d;
  logic [7:0]  cap;
  logic        wr_hit, m2_rise, m2_fall;
  logic [31:0] prg_full, chr_full;
  logic        unused_ok;

`ifdef BUS_CONFLICT_EN
  assign cap = bus.cpu_data_in & bus.prg_rdata;
`else
  assign cap = bus.cpu_data_in;
`endif

  assign wr_hit  = ~bus.cpu_rw & bus.cpu_addr[15];
  assign m2_rise = m2_s2 & ~m2_d;
  assign m2_fall = ~m2_s2 & m2_d;

  // M2 synchroniser, edge history and bank/capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_s1   <= 1'b0;
      m2_s2   <= 1'b0;
      m2_d    <= 1'b0;
      state_q <= IDLE;
      data_q  <= 8'h00;
      bank_q  <= 8'h00;
    end else begin
      m2_s1   <= bus.m2;
      m2_s2   <= m2_s1;
      m2_d    <= m2_s2;
      state_q <= state_d;
      data_q  <= data_d;
      bank_q  <= bank_d;
    end
  end

  // Arm on a write-cycle M2 rise, track data while armed, commit once on the M2 fall
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bank_d  = bank_q;
    unique case (state_q)
      IDLE: begin
        if (m2_rise && wr_hit) begin
          state_d = ARMED;
          data_d  = cap;
        end
      end
      ARMED: begin
        if (!wr_hit) begin
          state_d = IDLE;
        end else begin
          data_d = cap;
          if (m2_fall) state_d = COMMIT;
        end
      end
      COMMIT: begin
        bank_d  = data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address mapping; unsupported modes fall through to fixed 32K PRG / CHR bank 0
  always_comb begin
    prg_full = 32'(bus.cpu_addr[14:0]);
    chr_full = 32'(bus.ppu_addr[12:0]);
    case (MODE)
      32'd0: prg_full = ((bus.cpu_addr[14] ? PRG_MASK : (32'(bank_q) & PRG_MASK)) << 14)
                        | 32'(bus.cpu_addr[13:0]);
      32'd1: chr_full = ((32'(bank_q) & CHR_MASK) << 13) | 32'(bus.ppu_addr[12:0]);
      32'd2: prg_full = (32'(bank_q[2:0]) << 15) | 32'(bus.cpu_addr[14:0]);
      32'd3: begin
        prg_full = (32'(bank_q[5:4]) << 15) | 32'(bus.cpu_addr[14:0]);
        chr_full = (32'(bank_q[1:0]) << 13) | 32'(bus.ppu_addr[12:0]);
      end
      default: ;
    endcase
  end

  assign bus.prg_addr     = AW'(prg_full);
  assign bus.chr_addr     = AW'(chr_full);
  assign bus.ciram_a10    = (MODE == 32'd2) ? bank_q[4]
                          : (bus.mirroring ? bus.ppu_addr[10] : bus.ppu_addr[11]);
  assign bus.prg_oe       = bus.cpu_rw & bus.cpu_addr[15];
  assign bus.prg_we       = 1'b0;
  assign bus.chr_ce       = ~bus.ppu_addr[13];
  assign bus.ciram_ce     = ~bus.ppu_addr[13];
  assign bus.chr_oe       = ~bus.ppu_rd;
  assign bus.chr_we       = bus.chr_ram ? ~bus.ppu_wr : 1'b0;
  assign bus.wram_ce      = 1'b0;
  assign bus.cpu_data_oe  = 1'b0;
  assign bus.audio        = 16'h0000;
  assign bus.irq          = 1'b1;
  assign bus.sst_data_out = bank_q;

  // Bits that a given MODE/build does not consume
  assign unused_ok = ^{bus.prg_rdata, bus.cpu_addr[14:0], bus.ppu_addr, bank_q};
endmodule

// File: tb/tb_discrete_mapper.sv
// Scoreboard bench: one mapper per MODE (0..3 and unsupported 5) on shared stimulus, checked against an arithmetic model.
module tb_discrete_mapper;
  localparam int unsigned AW = 22;
  localparam int unsigned NM = 5;

  typedef struct packed {
    logic [AW-1:0] prg_addr;
    logic [AW-1:0] chr_addr;
    logic          ciram_a10;
    logic          ciram_ce;
    logic          prg_oe;
    logic          prg_we;
    logic          chr_ce;
    logic          chr_oe;
    logic          chr_we;
    logic          wram_ce;
    logic          cpu_data_oe;
    logic          irq;
    logic [15:0]   audio;
    logic [7:0]    sst;
  } obs_t;

  typedef struct packed {
    obs_t [NM-1:0] m;
  } probe_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_data_in;
  logic        m2;
  logic [7:0]  prg_rdata;
  logic [13:0] ppu_addr;
  logic        ppu_rd;
  logic        ppu_wr;
  logic        chr_ram;
  logic        mirroring;

  obs_t   act [NM];
  probe_t sb_q[$];
  probe_t mon_e;
  logic   probe_req;
  logic   end_req;
  int     checks;
  int     errors;
  int     model_bank;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NM; g++) begin : gm
    localparam int unsigned MD = (g == NM - 1) ? 5 : g;
    map_bus #(.ADDR_BITS(AW)) b ();
    assign b.cpu_addr    = cpu_addr;
    assign b.cpu_rw      = cpu_rw;
    assign b.cpu_data_in = cpu_data_in;
    assign b.m2          = m2;
    assign b.prg_rdata   = prg_rdata;
    assign b.ppu_addr    = ppu_addr;
    assign b.ppu_rd      = ppu_rd;
    assign b.ppu_wr      = ppu_wr;
    assign b.chr_ram     = chr_ram;
    assign b.mirroring   = mirroring;
    discrete_mapper #(.MODE(MD)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    assign act[g] = {b.prg_addr, b.chr_addr, b.ciram_a10, b.ciram_ce, b.prg_oe, b.prg_we,
                     b.chr_ce, b.chr_oe, b.chr_we, b.wram_ce, b.cpu_data_oe, b.irq,
                     b.audio, b.sst_data_out};
  end

  function automatic int mode_of(int k);
    return (k == NM - 1) ? 5 : k;
  endfunction

  // Value the mapper latches for a write of d while the ROM drives r
  function automatic int cap(int d, int r);
    int keep;
    keep = 0;
`ifndef BUS_CONFLICT_EN
    keep = 255;
`endif
    return (d & r) | (d & ~r & keep);
  endfunction

  function automatic obs_t model(int mode, int bank, int a, int rw, int p,
                                 int mir, int rd, int wr, int cram);
    obs_t o;
    int   prg;
    int   chr;
    prg = a % 32768;
    chr = p % 8192;
    case (mode)
      0: prg = (((a % 32768) >= 16384) ? 15 : bank % 16) * 16384 + a % 16384;
      1: chr = (bank % 4) * 8192 + p % 8192;
      2: prg = (bank % 8) * 32768 + a % 32768;
      3: begin
        prg = ((bank / 16) % 4) * 32768 + a % 32768;
        chr = (bank % 4) * 8192 + p % 8192;
      end
      default: ;
    endcase
    o.prg_addr    = AW'(prg);
    o.chr_addr    = AW'(chr);
    if (mode == 2) o.ciram_a10 = ((bank / 16) % 2) != 0;
    else if (mir != 0) o.ciram_a10 = ((p / 1024) % 2) != 0;
    else o.ciram_a10 = ((p / 2048) % 2) != 0;
    o.ciram_ce    = p < 8192;
    o.chr_ce      = p < 8192;
    o.prg_oe      = (rw != 0) && (a >= 32768);
    o.prg_we      = 1'b0;
    o.chr_oe      = rd == 0;
    o.chr_we      = (cram != 0) && (wr == 0);
    o.wram_ce     = 1'b0;
    o.cpu_data_oe = 1'b0;
    o.irq         = 1'b1;
    o.audio       = 16'h0000;
    o.sst         = 8'(bank);
    return o;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a read-side pattern and queue what every mapper should show for it
  task automatic probe(input logic [15:0] a, input logic rw, input logic [13:0] p);
    probe_t e;
    cpu_addr  = a;
    cpu_rw    = rw;
    ppu_addr  = p;
    mirroring = 1'($urandom_range(0, 1));
    ppu_rd    = 1'($urandom_range(0, 1));
    ppu_wr    = 1'($urandom_range(0, 1));
    chr_ram   = 1'($urandom_range(0, 1));
    for (int k = 0; k < NM; k++)
      e.m[k] = model(mode_of(k), model_bank, int'(a), int'(rw), int'(p),
                     int'(mirroring), int'(ppu_rd), int'(ppu_wr), int'(chr_ram));
    sb_q.push_back(e);
    probe_req = 1'b1;
    tick(1);
    probe_req = 1'b0;
  endtask

  // One CPU bus cycle; d2 replaces d mid-pulse, abort raises R/W while the write is armed
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                           input logic [7:0] d2, input logic [7:0] r, input bit abort);
    cpu_addr    = a;
    cpu_rw      = rw;
    cpu_data_in = d;
    prg_rdata   = r;
    tick(2);
    m2 = 1'b1;
    tick(3);
    cpu_data_in = d2;
    if (abort) cpu_rw = 1'b1;
    tick(3);
    m2 = 1'b0;
    tick(6);
    cpu_rw = 1'b1;
    tick(1);
    if (!rw && a[15] && !abort) model_bank = cap(int'(d2), int'(r));
  endtask

  always @(negedge clk) begin
    if (probe_req) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: probe seen with no expected entry");
      end else begin
        mon_e = sb_q.pop_front();
        for (int k = 0; k < NM; k++) begin
          checks++;
          if (act[k] !== mon_e.m[k]) begin
            errors++;
            $display("FAIL probe mode=%0d got=%h exp=%h", mode_of(k), act[k], mon_e.m[k]);
          end
        end
      end
    end
    if (end_req) begin
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_leftover: got %0d pending, exp 0", sb_q.size());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    model_bank = 0;
    probe_req = 1'b0;
    end_req = 1'b0;
    rst_n = 1'b1;
    cpu_addr = 16'h0000;
    cpu_rw = 1'b1;
    cpu_data_in = 8'h00;
    m2 = 1'b0;
    prg_rdata = 8'hFF;
    ppu_addr = 14'h0000;
    ppu_rd = 1'b1;
    ppu_wr = 1'b1;
    chr_ram = 1'b0;
    mirroring = 1'b0;
    #2;
    rst_n = 1'b0;
    tick(2);
    probe(16'h8000, 1'b1, 14'h0456);
    rst_n = 1'b1;
    tick(2);
    probe(16'h8000, 1'b1, 14'h0000);
    probe(16'hC000, 1'b1, 14'h1FFF);

    bus_cycle(16'h8000, 1'b0, 8'h05, 8'h05, 8'hFF, 1'b0);
    probe(16'h8123, 1'b1, 14'h0123);
    probe(16'hC000, 1'b1, 14'h2400);

    bus_cycle(16'h9000, 1'b0, 8'h03, 8'h03, 8'hFF, 1'b0);
    probe(16'h8000, 1'b1, 14'h0456);

    bus_cycle(16'hA000, 1'b0, 8'h12, 8'h12, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) probe(16'h8000 + 16'(i * 16'h1000), 1'b1, 14'h2000 + 14'(i * 14'h0400));
    bus_cycle(16'hA000, 1'b0, 8'h02, 8'h02, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) probe(16'h8000, 1'b1, 14'h2000 + 14'(i * 14'h0400));

    bus_cycle(16'h8000, 1'b0, 8'h0F, 8'h0F, 8'h05, 1'b0);
    probe(16'h8000, 1'b1, 14'h0000);

    // Write held low across three M2 cycles
    cpu_addr = 16'h8000;
    cpu_rw = 1'b0;
    prg_rdata = 8'hFF;
    for (int i = 1; i <= 3; i++) begin
      cpu_data_in = 8'(i);
      tick(2);
      m2 = 1'b1;
      tick(6);
      m2 = 1'b0;
      tick(6);
      model_bank = cap(i, 255);
      probe(16'h8000, 1'b0, 14'($urandom));
    end
    cpu_rw = 1'b1;
    tick(2);

    // Reset while the write is armed
    cpu_addr = 16'h8000;
    cpu_rw = 1'b0;
    cpu_data_in = 8'h07;
    tick(2);
    m2 = 1'b1;
    tick(5);
    rst_n = 1'b0;
    model_bank = 0;
    tick(2);
    m2 = 1'b0;
    cpu_rw = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(8);
    probe(16'h8000, 1'b1, 14'h0000);

    for (int it = 0; it < 40; it++) begin
      int          kind;
      logic [15:0] a;
      kind = int'($urandom_range(0, 9));
      a = {(kind != 1), 15'($urandom)};
      bus_cycle(a, (kind == 0), 8'($urandom), 8'($urandom), 8'($urandom), (kind == 2));
      probe(16'($urandom), 1'($urandom_range(0, 1)), 14'($urandom));
      probe(16'h8000 | 16'($urandom), 1'b1, 14'($urandom));
    end

    tick(2);
    end_req = 1'b1;
    tick(1);
    end_req = 1'b0;
    tick(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
